delay_line_ctrl: RTL and testbench
==================================

Name: delay_line_ctrl

Overview:
- Controller that sequences the dual-port RAM of the signal-delay datapath as a programmable delay line.
- Accepts microphone samples through a valid/ready handshake and generates the RAM write/read enables and addresses. Read address is always the write pointer minus the programmed delay.
- Gates output validity until the line has been primed with `delay` samples.
- Sits between the sample source / config registers and the existing RAM; carries no sample data itself.

Parameters:
- ADDR_WIDTH, 8, RAM address width; RAM depth is 2^ADDR_WIDTH.
- DEFAULT_DELAY, 16, delay in samples loaded at reset; must be in 1..2^ADDR_WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  run enable; low pauses the controller (no accepts, state and pointers held).
- in_valid  input  1  source has a sample on the RAM din bus.
- in_ready  output  1  controller accepts the sample this cycle.
- cfg_load  input  1  single-cycle strobe to load a new delay.
- delay_cfg  input  ADDR_WIDTH  new delay value, sampled when cfg_load=1.
- ram_wr_en  output  1  RAM write enable.
- ram_wr_addr  output  ADDR_WIDTH  RAM write address.
- ram_rd_en  output  1  RAM read enable.
- ram_rd_addr  output  ADDR_WIDTH  RAM read address.
- out_valid  output  1  RAM dout holds a valid delayed sample this cycle.
- primed  output  1  high while in RUN.
- delay_q  output  ADDR_WIDTH  currently active delay.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; wr_ptr=0; fill=0; delay_q=DEFAULT_DELAY.
  - out_valid=0, primed=0, in_ready=0, ram_wr_en=0, ram_rd_en=0.
- States:
  - IDLE: leave to PRIME on the first cycle en=1.
  - PRIME: count written samples.
  - RUN: steady state.
- in_ready = en & (state!=IDLE) & ~cfg_load. It is combinational and must not depend on in_valid.
- accept = in_valid & in_ready. All outputs below are combinational from registered state.
  - ram_wr_en = accept; ram_wr_addr = wr_ptr.
  - ram_rd_addr = (wr_ptr - delay_q) mod 2^ADDR_WIDTH.
  - ram_rd_en = accept & (fill >= delay_q).
- On accept: wr_ptr increments, wrapping 2^ADDR_WIDTH-1 -> 0. fill increments, saturating at delay_q.
- PRIME -> RUN on the accept where fill == delay_q-1, so the following accept is the first read.
  - Consequence: the first valid output is the sample written delay_q accepts earlier.
- out_valid is registered and equals ram_rd_en delayed one cycle, matching the RAM's one-cycle read latency. It is a single-cycle pulse per read.
- cfg_load=1 (any state except IDLE, regardless of en):
  - delay_q <= delay_cfg, except delay_cfg=0 is clamped to 1.
  - fill <= 0; state <= PRIME; wr_ptr unchanged.
  - The sample in that cycle is not accepted (in_ready=0).
  - An out_valid already in flight from the previous cycle still asserts.
- cfg_load in IDLE: only delay_q is updated.
- en=0 mid-stream: no accepts. Pointers, fill, state and delay_q are held. Any pending out_valid completes.
- Read and write never address the same location in the same cycle, since delay_q >= 1.
- Reset mid-operation: immediate return to reset values; the RAM contents are don't-care.

Optional Feature:
- Macro: DELAY_LINE_CTRL_ZERO_FILL_EN.
- Defined:
  - Adds output out_zero (1 bit).
  - In PRIME, every accept also produces an out_valid pulse one cycle later, with out_zero=1; downstream substitutes 0 for RAM dout. This keeps the output sample rate continuous during priming.
  - In RUN, out_zero=0. Reset value of out_zero is 0.
- Undefined: out_zero port absent; out_valid pulses only for real reads.

Decomposition:
- Package delay_line_ctrl_pkg:
  - typedef enum logic [1:0] state_t {IDLE, PRIME, RUN}.
  - Localparam MIN_DELAY=1.
- Sub-module delay_ptr (ADDR_WIDTH): wrapping write pointer with enable. It exports the pointer and the combinational pointer-minus-delay read address.
- fill counter and FSM live in the top.

Test Plan:
- Reset, en=1, DEFAULT_DELAY=16, in_valid held 1 → ram_rd_en first high on accept 17 with ram_rd_addr=0 and ram_wr_addr=16; out_valid high the next cycle; primed rises after accept 16.
- Wrap: ADDR_WIDTH=4, delay 3, stream 20 samples → wr_addr wraps 15→0; at wr_ptr=1, rd_addr=14; no gap in out_valid.
- cfg_load with delay_cfg=5 while in RUN with in_valid=1 → in_ready=0 that cycle; delay_q=5; next 5 accepts have ram_rd_en=0; 6th accept reads wr_ptr-5.
- delay_cfg=0 loaded → delay_q=1; after 1 write, each accept reads the previous address.
- en toggled low for 3 cycles mid-RUN with in_valid=1 → no ram_wr_en/ram_rd_en; wr_ptr unchanged; a pending out_valid still fires; stream resumes seamlessly.
- rst asserted asynchronously mid-RUN (not on a clock edge) → all outputs 0 immediately; delay_q=DEFAULT_DELAY; with ZERO_FILL_EN defined, the first 16 accepts afterwards give out_valid with out_zero=1.

Source files
------------

// File: rtl/delay_line_ctrl_pkg.sv
// Shared types and constants for the delay-line controller.
// Optional feature macro: DELAY_LINE_CTRL_ZERO_FILL_EN (see delay_line_ctrl.sv).
package delay_line_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_t;

   // Smallest legal delay; a zero request is clamped up to this.
   localparam int MIN_DELAY = 1;

endpackage

// File: rtl/delay_line_ctrl_if.sv
// Handshake, config and RAM-control bundle between the sample source,
// the config registers, the delay-line controller and the RAM.
// Optional feature macro: DELAY_LINE_CTRL_ZERO_FILL_EN adds out_zero.
interface delay_line_ctrl_if #(
   parameter int ADDR_WIDTH = 8
);

   logic                  in_valid;
   logic                  in_ready;
   logic                  cfg_load;
   logic [ADDR_WIDTH-1:0] delay_cfg;
   logic                  ram_wr_en;
   logic [ADDR_WIDTH-1:0] ram_wr_addr;
   logic                  ram_rd_en;
   logic [ADDR_WIDTH-1:0] ram_rd_addr;
   logic                  out_valid;
   logic                  primed;
   logic [ADDR_WIDTH-1:0] delay_q;
`ifdef DELAY_LINE_CTRL_ZERO_FILL_EN
   logic                  out_zero;

   // Source / config side.
   modport master (
      output in_valid, cfg_load, delay_cfg,
      input  in_ready, ram_wr_en, ram_wr_addr, ram_rd_en, ram_rd_addr,
      input  out_valid, primed, delay_q, out_zero
   );

   // Controller side.
   modport slave (
      input  in_valid, cfg_load, delay_cfg,
      output in_ready, ram_wr_en, ram_wr_addr, ram_rd_en, ram_rd_addr,
      output out_valid, primed, delay_q, out_zero
   );
`else
   // Source / config side.
   modport master (
      output in_valid, cfg_load, delay_cfg,
      input  in_ready, ram_wr_en, ram_wr_addr, ram_rd_en, ram_rd_addr,
      input  out_valid, primed, delay_q
   );

   // Controller side.
   modport slave (
      input  in_valid, cfg_load, delay_cfg,
      output in_ready, ram_wr_en, ram_wr_addr, ram_rd_en, ram_rd_addr,
      output out_valid, primed, delay_q
   );
`endif

endinterface

// File: rtl/delay_line_ctrl_ptr.sv
// Wrapping write pointer for the delay-line RAM plus the derived read
// address (write pointer minus delay, modulo RAM depth).
module delay_ptr #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_inc,
   input  logic [ADDR_WIDTH-1:0] i_delay,
   output logic [ADDR_WIDTH-1:0] o_wr_ptr,
   output logic [ADDR_WIDTH-1:0] o_rd_addr
);

   logic [ADDR_WIDTH-1:0] r_wr_ptr;

   // Advance one slot per written sample; natural wrap at 2^ADDR_WIDTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
      end else if (i_inc) begin
         r_wr_ptr <= r_wr_ptr + 1'b1;
      end
   end

   assign o_wr_ptr  = r_wr_ptr;
   // Modular subtraction gives the wrapped read address for free.
   assign o_rd_addr = r_wr_ptr - i_delay;

endmodule

// File: rtl/delay_line_ctrl.sv
// Delay-line controller: sequences a dual-port RAM so that each accepted
// sample is read back delay_q accepts later. Carries no sample data.
// Optional feature macro: DELAY_LINE_CTRL_ZERO_FILL_EN -- while priming,
// every accept also yields an out_valid pulse flagged with out_zero so the
// output sample rate stays continuous.
module delay_line_ctrl
   import delay_line_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH    = 8,
   parameter int DEFAULT_DELAY = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   delay_line_ctrl_if.slave   bus
);

   // Zero requests become the minimum delay so read never collides with write.
   function automatic logic [ADDR_WIDTH-1:0] clamp_delay(input logic [ADDR_WIDTH-1:0] d);
      return (d == '0) ? ADDR_WIDTH'(MIN_DELAY) : d;
   endfunction

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_fill;
   logic [ADDR_WIDTH-1:0] w_fill_nxt;
   logic [ADDR_WIDTH-1:0] r_delay_q;
   logic [ADDR_WIDTH-1:0] w_delay_nxt;
   logic                  r_out_valid;
   logic                  r_out_zero;
   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_rd_en;
   logic                  w_prime_acc;
   logic [ADDR_WIDTH-1:0] w_wr_ptr;
   logic [ADDR_WIDTH-1:0] w_rd_addr;

   // cfg_load steals the cycle, so ready never depends on in_valid.
   assign w_in_ready  = en && (r_state != IDLE) && !bus.cfg_load;
   assign w_accept    = bus.in_valid && w_in_ready;
   // Fill saturates at delay_q, so reaching it means the line is primed.
   assign w_rd_en     = w_accept && (r_fill >= r_delay_q);
   assign w_prime_acc = w_accept && (r_state == PRIME);

   delay_ptr #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ptr (
      .clk       (clk),
      .rst       (rst),
      .i_inc     (w_accept),
      .i_delay   (r_delay_q),
      .o_wr_ptr  (w_wr_ptr),
      .o_rd_addr (w_rd_addr)
   );

   // Next-state, fill and delay update; cfg_load overrides any accept.
   always_comb begin
      w_state_nxt = r_state;
      w_fill_nxt  = r_fill;
      w_delay_nxt = r_delay_q;
      case (r_state)
         IDLE: begin
            if (bus.cfg_load) begin
               w_delay_nxt = clamp_delay(bus.delay_cfg);
            end
            if (en) begin
               w_state_nxt = PRIME;
            end
         end
         PRIME, RUN: begin
            if (bus.cfg_load) begin
               w_delay_nxt = clamp_delay(bus.delay_cfg);
               w_fill_nxt  = '0;
               w_state_nxt = PRIME;
            end else if (w_accept) begin
               if (r_fill < r_delay_q) begin
                  w_fill_nxt = r_fill + 1'b1;
               end
               // Switch on the last priming write so the next accept reads.
               if ((r_state == PRIME) && (r_fill == (r_delay_q - 1'b1))) begin
                  w_state_nxt = RUN;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Control registers; out_valid mirrors the RAM's one-cycle read latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_fill      <= '0;
         r_delay_q   <= ADDR_WIDTH'(DEFAULT_DELAY);
         r_out_valid <= 1'b0;
         r_out_zero  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_fill      <= w_fill_nxt;
         r_delay_q   <= w_delay_nxt;
`ifdef DELAY_LINE_CTRL_ZERO_FILL_EN
         r_out_valid <= w_rd_en || w_prime_acc;
`else
         r_out_valid <= w_rd_en;
`endif
         r_out_zero  <= w_prime_acc;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.ram_wr_en   = w_accept;
   assign bus.ram_wr_addr = w_wr_ptr;
   assign bus.ram_rd_en   = w_rd_en;
   assign bus.ram_rd_addr = w_rd_addr;
   assign bus.out_valid   = r_out_valid;
   assign bus.primed      = (r_state == RUN);
   assign bus.delay_q     = r_delay_q;
`ifdef DELAY_LINE_CTRL_ZERO_FILL_EN
   assign bus.out_zero    = r_out_zero;
`else
   // Zero flag only leaves the block in the zero-fill build.
   logic w_unused_zero;
   assign w_unused_zero = r_out_zero;
`endif

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl (ADDR_WIDTH=8, DEFAULT_DELAY=16).
// Honours DELAY_LINE_CTRL_ZERO_FILL_EN when defined.
module tb_delay_line_ctrl;

`ifdef DELAY_LINE_CTRL_ZERO_FILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif

   logic clk;
   logic rst;
   logic en;
   int   n_tests;
   int   n_fail;

   delay_line_ctrl_if #(.ADDR_WIDTH(8)) dl_if ();

   delay_line_ctrl #(
      .ADDR_WIDTH    (8),
      .DEFAULT_DELAY (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .bus (dl_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From an IDLE cycle with en=1/in_valid=1: 17 accepts at delay 16.
   task automatic prime_seq();
      for (int k = 1; k <= 17; k++) begin
         tick();
         chk("pr_ready",  32'(dl_if.in_ready), 32'd1);
         chk("pr_wr_en",  32'(dl_if.ram_wr_en), 32'd1);
         chk("pr_wr_addr", 32'(dl_if.ram_wr_addr), 32'(k - 1));
         chk("pr_rd_en",  32'(dl_if.ram_rd_en), 32'(k == 17));
         chk("pr_primed", 32'(dl_if.primed), 32'(k == 17));
         chk("pr_ov",     32'(dl_if.out_valid), 32'(ZF && (k >= 2)));
`ifdef DELAY_LINE_CTRL_ZERO_FILL_EN
         chk("pr_oz",     32'(dl_if.out_zero), 32'(k >= 2));
`endif
         if (k == 17) chk("pr_rd_addr", 32'(dl_if.ram_rd_addr), 32'd0);
      end
      tick();
      chk("pr_ov_first", 32'(dl_if.out_valid), 32'd1);
`ifdef DELAY_LINE_CTRL_ZERO_FILL_EN
      chk("pr_oz_run", 32'(dl_if.out_zero), 32'd0);
`endif
      chk("pr_wr17", 32'(dl_if.ram_wr_addr), 32'd17);
      chk("pr_rd1",  32'(dl_if.ram_rd_addr), 32'd1);
      chk("pr_rd_en18", 32'(dl_if.ram_rd_en), 32'd1);
   endtask

   initial begin
      logic [7:0] wp;
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0;
      en  = 1'b0;
      dl_if.in_valid  = 1'b0;
      dl_if.cfg_load  = 1'b0;
      dl_if.delay_cfg = 8'd0;

      // Reset state
      #22;
      chk("rst_ready",  32'(dl_if.in_ready), 32'd0);
      chk("rst_ov",     32'(dl_if.out_valid), 32'd0);
      chk("rst_primed", 32'(dl_if.primed), 32'd0);
      chk("rst_wr_en",  32'(dl_if.ram_wr_en), 32'd0);
      chk("rst_rd_en",  32'(dl_if.ram_rd_en), 32'd0);
      chk("rst_delay",  32'(dl_if.delay_q), 32'd16);
      chk("rst_wr_addr", 32'(dl_if.ram_wr_addr), 32'd0);
      en = 1'b1;
      dl_if.in_valid = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("idle_ready", 32'(dl_if.in_ready), 32'd0);
      chk("idle_wr_en", 32'(dl_if.ram_wr_en), 32'd0);

      // Priming at default delay
      prime_seq();

      // cfg_load delay 5 in RUN
      dl_if.cfg_load  = 1'b1;
      dl_if.delay_cfg = 8'd5;
      #1;
      chk("cfg_ready", 32'(dl_if.in_ready), 32'd0);
      chk("cfg_wr_en", 32'(dl_if.ram_wr_en), 32'd0);
      chk("cfg_rd_en", 32'(dl_if.ram_rd_en), 32'd0);
      chk("cfg_ov_inflight", 32'(dl_if.out_valid), 32'd1);
      chk("cfg_delay_old", 32'(dl_if.delay_q), 32'd16);
      tick();
      dl_if.cfg_load = 1'b0;
      #1;
      for (int j = 1; j <= 6; j++) begin
         if (j == 1) chk("d5_delay", 32'(dl_if.delay_q), 32'd5);
         chk("d5_wr_addr", 32'(dl_if.ram_wr_addr), 32'(17 + j - 1));
         chk("d5_rd_en",   32'(dl_if.ram_rd_en), 32'(j == 6));
         chk("d5_primed",  32'(dl_if.primed), 32'(j == 6));
         chk("d5_ov",      32'(dl_if.out_valid), 32'(ZF && (j >= 2)));
         if (j == 6) chk("d5_rd_addr", 32'(dl_if.ram_rd_addr), 32'd17);
         tick();
      end
      chk("d5_ov_first", 32'(dl_if.out_valid), 32'd1);
      chk("d5_wr23", 32'(dl_if.ram_wr_addr), 32'd23);

      // en low for 3 cycles mid-RUN
      en = 1'b0;
      #1;
      chk("en0_ready", 32'(dl_if.in_ready), 32'd0);
      chk("en0_wr_en", 32'(dl_if.ram_wr_en), 32'd0);
      chk("en0_rd_en", 32'(dl_if.ram_rd_en), 32'd0);
      chk("en0_ov_pending", 32'(dl_if.out_valid), 32'd1);
      tick();
      for (int c = 0; c < 2; c++) begin
         chk("en0_ov",      32'(dl_if.out_valid), 32'd0);
         chk("en0_wr_hold", 32'(dl_if.ram_wr_addr), 32'd23);
         chk("en0_wr_en2",  32'(dl_if.ram_wr_en), 32'd0);
         chk("en0_primed",  32'(dl_if.primed), 32'd1);
         tick();
      end
      en = 1'b1;
      #1;
      chk("en1_wr_en",   32'(dl_if.ram_wr_en), 32'd1);
      chk("en1_wr_addr", 32'(dl_if.ram_wr_addr), 32'd23);
      chk("en1_rd_en",   32'(dl_if.ram_rd_en), 32'd1);
      chk("en1_rd_addr", 32'(dl_if.ram_rd_addr), 32'd18);
      tick();
      chk("en1_ov",   32'(dl_if.out_valid), 32'd1);
      chk("en1_wr24", 32'(dl_if.ram_wr_addr), 32'd24);

      // delay_cfg=0 clamps to 1
      dl_if.cfg_load  = 1'b1;
      dl_if.delay_cfg = 8'd0;
      #1;
      chk("d0_ready", 32'(dl_if.in_ready), 32'd0);
      tick();
      dl_if.cfg_load = 1'b0;
      #1;
      chk("d0_delay",   32'(dl_if.delay_q), 32'd1);
      chk("d0_wr_addr", 32'(dl_if.ram_wr_addr), 32'd24);
      chk("d0_rd_en",   32'(dl_if.ram_rd_en), 32'd0);
      chk("d0_primed",  32'(dl_if.primed), 32'd0);
      chk("d0_ov",      32'(dl_if.out_valid), 32'd0);
      tick();
      chk("d1_primed",  32'(dl_if.primed), 32'd1);
      chk("d1_rd_en",   32'(dl_if.ram_rd_en), 32'd1);
      chk("d1_wr_addr", 32'(dl_if.ram_wr_addr), 32'd25);
      chk("d1_rd_addr", 32'(dl_if.ram_rd_addr), 32'd24);
      chk("d1_ov",      32'(dl_if.out_valid), 32'(ZF));
      tick();
      chk("d1_rd_addr2", 32'(dl_if.ram_rd_addr), 32'd25);
      chk("d1_wr_addr2", 32'(dl_if.ram_wr_addr), 32'd26);
      chk("d1_ov2",      32'(dl_if.out_valid), 32'd1);

      // Wrap with delay 3
      dl_if.cfg_load  = 1'b1;
      dl_if.delay_cfg = 8'd3;
      tick();
      dl_if.cfg_load = 1'b0;
      #1;
      for (int idx = 1; idx <= 232; idx++) begin
         wp = 8'(26 + idx - 1);
         chk("wr_wr_addr", 32'(dl_if.ram_wr_addr), 32'(wp));
         chk("wr_rd_addr", 32'(dl_if.ram_rd_addr), 32'(8'(wp - 8'd3)));
         chk("wr_rd_en",   32'(dl_if.ram_rd_en), 32'(idx >= 4));
         chk("wr_ov",      32'(dl_if.out_valid), 32'((idx >= 5) || (ZF && (idx >= 2))));
         if (wp == 8'd1) chk("wrap_rd_254", 32'(dl_if.ram_rd_addr), 32'd254);
         tick();
      end
      chk("wr_after", 32'(dl_if.ram_wr_addr), 32'd2);

      // Asynchronous reset mid-RUN, away from the clock edge
      #3 rst = 1'b0;
      #1;
      chk("arst_ov",     32'(dl_if.out_valid), 32'd0);
      chk("arst_ready",  32'(dl_if.in_ready), 32'd0);
      chk("arst_wr_en",  32'(dl_if.ram_wr_en), 32'd0);
      chk("arst_rd_en",  32'(dl_if.ram_rd_en), 32'd0);
      chk("arst_primed", 32'(dl_if.primed), 32'd0);
      chk("arst_delay",  32'(dl_if.delay_q), 32'd16);
      chk("arst_wr_addr", 32'(dl_if.ram_wr_addr), 32'd0);
`ifdef DELAY_LINE_CTRL_ZERO_FILL_EN
      chk("arst_oz", 32'(dl_if.out_zero), 32'd0);
`endif
      #2 rst = 1'b1;
      #1;
      chk("arst_idle_ready", 32'(dl_if.in_ready), 32'd0);
      prime_seq();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
